// File: rtl/csamul_pipe.sv
// Pipelined carry-save array multiplier: N-bit operands, per-transaction unsigned or
// Baugh-Wooley signed mode, ROWS_PER_STAGE array rows per register stage.

module csamul_pipe_stage #(
    parameter int N  = 8,
    parameter int K0 = 1,
    parameter int NR = 2
) (
    input  logic [N-1:0]  i_s,
    input  logic [N-1:0]  i_c,
    input  logic [N-1:0]  i_a,
    input  logic [NR-1:0] i_b,
    input  logic          i_tc,
    output logic [N-1:0]  o_s,
    output logic [N-1:0]  o_c,
    output logic [NR-1:0] o_lo
);
    // s/c enter aligned to weight K0; each row retires one product bit and slides the window up.
    logic [NR:0][N-1:0] w_s, w_c;

    assign w_s[0] = i_s;
    assign w_c[0] = i_c;

    for (genvar r = 0; r < NR; r++) begin : g_row
        localparam bit MSB_ROW = (K0 + r == N - 1);
        logic [N-1:0] w_pp, w_sum, w_cy;
        for (genvar j = 0; j < N; j++) begin : g_col
            localparam bit FLIP = ((j == N - 1) != MSB_ROW);
            assign w_pp[j] = (i_a[j] & i_b[r]) ^ (FLIP & i_tc);
        end
        assign w_sum    = w_s[r] ^ w_c[r] ^ w_pp;
        assign w_cy     = (w_s[r] & w_c[r]) | (w_s[r] & w_pp) | (w_c[r] & w_pp);
        assign o_lo[r]  = w_sum[0];
        assign w_s[r+1] = {1'b0, w_sum[N-1:1]};
        assign w_c[r+1] = w_cy;
    end

    assign o_s = w_s[NR];
    assign o_c = w_c[NR];
endmodule

module csamul_pipe #(
    parameter int N              = 8,
    parameter int ROWS_PER_STAGE = 2,
    parameter int OUT_REG        = 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    input  logic           tc,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] out_data,
    output logic           out_tc
);
    localparam int S = (N + ROWS_PER_STAGE - 2) / ROWS_PER_STAGE;

    logic         w_adv, w_acc;
    logic [N-1:0] w_pp0, w_s0, w_p0;

    assign w_adv    = !out_valid || out_ready;
    assign in_ready = w_adv && !rst;
    assign w_acc    = in_valid && in_ready;

    // Row 0 has only the MSB-column term inverted; the weight-N correction uses the free top slot of s.
    assign w_pp0 = (a & {N{b[0]}}) ^ {tc, {(N-1){1'b0}}};
    assign w_s0  = {tc, w_pp0[N-1:1]};
    assign w_p0  = {{(N-1){1'b0}}, w_pp0[0]};

    for (genvar st = 1; st <= S; st++) begin : g_stg
        localparam int K0 = 1 + (st - 1) * ROWS_PER_STAGE;
        localparam int NR = (N - K0 < ROWS_PER_STAGE) ? (N - K0) : ROWS_PER_STAGE;

        logic [N-1:0]    w_is, w_ic, w_ip, w_ia, w_os, w_oc, w_lo_w;
        logic [N-K0-1:0] w_ib;
        logic [NR-1:0]   w_lo;
        logic            w_itc, w_iv;
        logic [N-1:0]    r_s, r_c, r_p;
        logic            r_tc, r_vld;

        if (st == 1) begin : g_first
            assign w_is  = w_s0;
            assign w_ic  = '0;
            assign w_ip  = w_p0;
            assign w_ia  = a;
            assign w_ib  = b[N-1:1];
            assign w_itc = tc;
            assign w_iv  = w_acc;
        end else begin : g_next
            assign w_is  = g_stg[st-1].r_s;
            assign w_ic  = g_stg[st-1].r_c;
            assign w_ip  = g_stg[st-1].r_p;
            assign w_ia  = g_stg[st-1].g_opnd.r_a;
            assign w_ib  = g_stg[st-1].g_opnd.r_b;
            assign w_itc = g_stg[st-1].r_tc;
            assign w_iv  = g_stg[st-1].r_vld;
        end

        csamul_pipe_stage #(.N(N), .K0(K0), .NR(NR)) u_stage (
            .i_s  (w_is),
            .i_c  (w_ic),
            .i_a  (w_ia),
            .i_b  (w_ib[NR-1:0]),
            .i_tc (w_itc),
            .o_s  (w_os),
            .o_c  (w_oc),
            .o_lo (w_lo)
        );

        assign w_lo_w = {{(N-NR){1'b0}}, w_lo};

        always_ff @(posedge clk) begin
            if (rst) begin
                r_vld <= 1'b0;
            end else if (w_adv) begin
                r_vld <= w_iv;
                r_s   <= w_os;
                r_c   <= w_oc;
                r_p   <= w_ip | (w_lo_w << K0);
                r_tc  <= w_itc;
            end
        end

        // Operand bits are only carried while later rows still need them.
        if (st < S) begin : g_opnd
            logic [N-1:0]       r_a;
            logic [N-K0-NR-1:0] r_b;
            always_ff @(posedge clk) begin
                if (w_adv) begin
                    r_a <= w_ia;
                    r_b <= w_ib[N-K0-1:NR];
                end
            end
        end
    end

    logic           w_lvld, w_ltc;
    logic [N-1:0]   w_hi;
    logic [2*N-1:0] w_prod;

    assign w_lvld = g_stg[S].r_vld;
    assign w_ltc  = g_stg[S].r_tc;
    // The weight 2N-1 correction can only toggle the MSB of the high half.
    assign w_hi   = (g_stg[S].r_s + g_stg[S].r_c) ^ {w_ltc, {(N-1){1'b0}}};
    assign w_prod = {w_hi, g_stg[S].r_p};

    if (OUT_REG != 0) begin : g_oreg
        logic           r_ov, r_otc;
        logic [2*N-1:0] r_od;
        always_ff @(posedge clk) begin
            if (rst) begin
                r_ov  <= 1'b0;
                r_otc <= 1'b0;
                r_od  <= '0;
            end else if (w_adv) begin
                r_ov <= w_lvld;
                if (w_lvld) begin
                    r_od  <= w_prod;
                    r_otc <= w_ltc;
                end
            end
        end
        assign out_valid = r_ov;
        assign out_data  = r_od;
        assign out_tc    = r_otc;
    end else begin : g_ocomb
        assign out_valid = w_lvld;
        assign out_data  = w_lvld ? w_prod : '0;
        assign out_tc    = w_lvld & w_ltc;
    end
endmodule

// File: tb/tb_csamul_pipe.sv
// Bench for csamul_pipe: N=8/R=2/registered output under directed, bubble, stall, reset and
// random traffic, plus an exhaustive N=4/R=3 combinational-output instance.

module tb_csamul_pipe;
    localparam int N = 8;
    localparam int R = 2;
    localparam int L = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst, in_valid, in_ready, tc, out_valid, out_ready, out_tc;
    logic [N-1:0]   a, b;
    logic [2*N-1:0] out_data;

    logic       in_valid2, in_ready2, tc2, out_valid2, out_ready2, out_tc2;
    logic [3:0] a2, b2;
    logic [7:0] out_data2;

    csamul_pipe #(.N(N), .ROWS_PER_STAGE(R), .OUT_REG(1)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .tc(tc), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_tc(out_tc)
    );

    csamul_pipe #(.N(4), .ROWS_PER_STAGE(3), .OUT_REG(0)) u_dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2),
        .a(a2), .b(b2), .tc(tc2), .out_valid(out_valid2), .out_ready(out_ready2),
        .out_data(out_data2), .out_tc(out_tc2)
    );

    typedef struct {
        logic [15:0] prod;
        logic        tc;
        int          t;
    } exp_t;

    exp_t       sbq[$];
    logic [8:0] q2[$];
    int         n_chk = 0;
    int         n_pass = 0;
    int         cyc = 0;
    int         n_acc = 0;
    bit         lat_chk = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Directed vectors with hand-derived products.
    logic [7:0]  da [8] = '{8'hFF, 8'h80, 8'h80, 8'hFF, 8'h80, 8'h7F, 8'hFF, 8'h00};
    logic [7:0]  db [8] = '{8'hFF, 8'h80, 8'h80, 8'h01, 8'h80, 8'h80, 8'hFF, 8'h5A};
    logic        dt [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [15:0] de [8] = '{16'hFE01, 16'h4000, 16'h4000, 16'hFFFF, 16'h4000, 16'hC080, 16'h0001, 16'h0000};

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] expv);
        n_chk++;
        if (got === expv) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, expv, cyc);
    endtask

    // Plain integer product of the operands interpreted per mode, truncated to 2w bits.
    function automatic longint mul_ref(input longint x, input longint y, input bit t, input int w);
        longint sx, sy;
        sx = x;
        sy = y;
        if (t) begin
            if (x >= (longint'(1) << (w - 1))) sx = x - (longint'(1) << w);
            if (y >= (longint'(1) << (w - 1))) sy = y - (longint'(1) << w);
        end
        return (sx * sy) & ((longint'(1) << (2 * w)) - 1);
    endfunction

    task automatic step(input bit r, input bit iv, input logic [7:0] ia, input logic [7:0] ib,
                        input bit itc, input bit ordy, input bit use_d, input logic [15:0] dexp);
        exp_t e;
        @(negedge clk);
        rst = r; in_valid = iv; a = ia; b = ib; tc = itc; out_ready = ordy;
        #1;
        if (out_valid === 1'b1 && out_ready) begin
            if (sbq.size() == 0) begin
                chk("spurious_out", out_valid, 0);
            end else begin
                e = sbq.pop_front();
                chk("out_data", out_data, e.prod);
                chk("out_tc", out_tc, e.tc);
                if (lat_chk) chk("latency", cyc - e.t, L);
            end
        end
        if (in_valid && in_ready === 1'b1) begin
            e.prod = use_d ? dexp : 16'(mul_ref(ia, ib, itc, N));
            e.tc   = itc;
            e.t    = cyc;
            sbq.push_back(e);
            n_acc++;
        end
    endtask

    task automatic drain();
        for (int k = 0; k < 40 && sbq.size() != 0; k++) step(0, 0, 0, 0, 0, 1, 0, 0);
        chk("drained", sbq.size(), 0);
    endtask

    initial begin
        logic [15:0] held;
        logic [8:0]  e2;
        bit          ordy;
        rst = 1; in_valid = 0; a = 0; b = 0; tc = 0; out_ready = 1;
        in_valid2 = 0; a2 = 0; b2 = 0; tc2 = 0; out_ready2 = 1;
        held = '0;

        step(1, 0, 0, 0, 0, 1, 0, 0);
        step(1, 0, 0, 0, 0, 1, 0, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_tc", out_tc, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_n4_valid", out_valid2, 0);
        chk("rst_n4_data", out_data2, 0);
        step(0, 0, 0, 0, 0, 1, 0, 0);
        chk("in_ready_after_rst", in_ready, 1);

        // Single unsigned all-ones product, then the back-to-back mixed-mode stream.
        lat_chk = 1;
        step(0, 1, da[0], db[0], dt[0], 1, 1, de[0]);
        drain();
        step(0, 0, 0, 0, 0, 1, 0, 0);
        chk("single_pulse", out_valid, 0);
        for (int i = 1; i < 8; i++) step(0, 1, da[i], db[i], dt[i], 1, 1, de[i]);
        step(0, 1, 8'hA5, 8'h00, 0, 1, 1, 16'h0000);
        drain();

        // Bubbles keep their spacing because each product has fixed latency.
        step(0, 1, 8'(($urandom)), 8'($urandom), 1'($urandom_range(0, 1)), 1, 0, 0);
        step(0, 0, 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), 1, 0, 0);
        step(0, 0, 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), 1, 0, 0);
        step(0, 1, 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), 1, 0, 0);
        drain();

        // Stall for 7 cycles while the head product is waiting.
        lat_chk = 0;
        n_acc = 0;
        for (int k = 0; k < 60 && (n_acc < 10 || sbq.size() != 0); k++) begin
            ordy = !(k >= 8 && k < 15);
            step(0, n_acc < 10, 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), ordy, 0, 0);
            if (k == 8) held = out_data;
            if (!ordy) begin
                chk("stall_in_ready", in_ready, 0);
                chk("stall_valid", out_valid, 1);
                if (k > 8) chk("stall_hold", out_data, held);
            end
        end
        chk("stall_count", n_acc, 10);
        drain();

        // Reset with three products in flight: none may emerge.
        for (int k = 0; k < 3; k++) step(0, 1, 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), 1, 0, 0);
        step(1, 1, 8'($urandom), 8'($urandom), 0, 1, 0, 0);
        chk("midrst_in_ready", in_ready, 0);
        sbq.delete();
        for (int k = 0; k < 10; k++) begin
            step(0, 0, 0, 0, 0, 1, 0, 0);
            if (k == 0) chk("in_ready_after_midrst", in_ready, 1);
            chk("midrst_quiet", out_valid, 0);
        end

        // Random traffic with random back-pressure.
        for (int k = 0; k < 3000; k++)
            step(0, 1'($urandom_range(0, 2) != 0), 8'($urandom), 8'($urandom),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0), 0, 0);
        drain();

        // Exhaustive N=4, both modes, combinational output one cycle after accept.
        for (int i = 0; i <= 512; i++) begin
            @(negedge clk);
            in_valid2 = (i < 512);
            {tc2, a2, b2} = 9'(i);
            #1;
            if (i > 0) begin
                chk("n4_valid", out_valid2, 1);
                if (q2.size() != 0) begin
                    e2 = q2.pop_front();
                    chk("n4_data", out_data2, e2[7:0]);
                    chk("n4_tc", out_tc2, e2[8]);
                end
            end
            if (in_valid2 && in_ready2 === 1'b1) q2.push_back({tc2, 8'(mul_ref(a2, b2, tc2, 4))});
        end
        @(negedge clk);
        #1;
        chk("n4_idle_valid", out_valid2, 0);
        chk("n4_idle_data", out_data2, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", n_chk);
        $fatal(1);
    end
endmodule
